// File: rtl/print_ctrl_pkg.sv
// ============================================================================
// Module   : print_ctrl_pkg
// Brief    : Shared encodings for the print controller: FSM states, CSR map,
//            STATUS field positions and CTRL start bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package print_ctrl_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_gap  = 2'd3;

    // Byte offsets relative to the CSR base (4*REG_NUMBER)
    localparam int unsigned c_csr_ctrl_ofs   = 32'h0;
    localparam int unsigned c_csr_status_ofs = 32'h4;

    localparam int unsigned c_stat_busy_bit    = 0;
    localparam int unsigned c_stat_done_bit    = 1;
    localparam int unsigned c_stat_timeout_bit = 2;
    localparam int unsigned c_stat_wr_err_bit  = 3;
    localparam int unsigned c_stat_words_lsb   = 8;

    localparam int unsigned c_ctrl_start_bit = 31;

endpackage

`default_nettype wire

// File: rtl/print_buf_regfile.sv
// ============================================================================
// Module   : print_buf_regfile
// Brief    : REG_NUMBER x 32 print buffer, one write port, one asynchronous
//            read port (word streaming) and one synchronous read port (bus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module print_buf_regfile #(
    parameter int unsigned REG_NUMBER = 16
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [$clog2(REG_NUMBER)-1:0] i_waddr,
    input  logic [31:0]                   i_wdata,
    input  logic [$clog2(REG_NUMBER)-1:0] i_araddr,
    output logic [31:0]                   o_ardata,
    input  logic                          i_re,
    input  logic [$clog2(REG_NUMBER)-1:0] i_raddr,
    output logic [31:0]                   o_rdata
);

    logic [31:0] r_mem [REG_NUMBER];
    logic [31:0] r_rdata;

    // Contents are deliberately left unreset so the array maps to plain RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_ardata = r_mem[i_araddr];
    assign o_rdata  = r_rdata;

endmodule

`default_nettype wire

// File: rtl/print_ctrl.sv
// ============================================================================
// Module   : print_ctrl
// Brief    : Bus-programmed print buffer that streams words to print_sub with
//            an enable/finish handshake, per-word timeout and completion IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module print_ctrl
    import print_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUMBER     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_i,
    input  logic                          bus_we_i,
    input  logic                          bus_re_i,
    input  logic [$clog2(REG_NUMBER)+2:0] bus_addr_i,
    input  logic [31:0]                   bus_wdata_i,
    output logic [31:0]                   bus_rdata_o,
    output logic                          write_soc_en_o,
    input  logic                          finish_i,
    output logic [$clog2(REG_NUMBER)+1:0] data_addr_o,
    output logic [31:0]                   data_o,
    output logic                          irq_o
);

    localparam int unsigned c_iw       = $clog2(REG_NUMBER);
    localparam int unsigned c_aw       = c_iw + 3;
    localparam logic [c_iw:0] c_len_max  = (c_iw + 1)'(REG_NUMBER);
    localparam logic [31:0]   c_tmo_last = 32'(TIMEOUT_CYCLES) - 32'd1;

    logic [1:0]      r_state;
    logic            r_en;
    logic [c_iw-1:0] r_index;
    logic [c_iw:0]   r_len;
    logic [c_iw+1:0] r_addr;
    logic [31:0]     r_tcnt;
    logic            r_done;
    logic            r_timeout;
    logic            r_wr_err;
    logic [7:0]      r_words;
    logic            r_rd_buf;
    logic [31:0]     r_csr_rdata;

    logic            w_is_csr;
    logic [c_iw-1:0] w_word;
    logic            w_busy;
    logic            w_ctrl_sel;
    logic            w_status_sel;
    logic            w_ctrl_we;
    logic            w_status_we;
    logic            w_buf_we;
    logic [c_iw:0]   w_len_req;
    logic [c_iw:0]   w_len_clamped;
    logic            w_tmo_hit;
    logic            w_last;
    logic [c_iw-1:0] w_index_nxt;
    logic [31:0]     w_status;
    logic [31:0]     w_buf_ardata;
    logic [31:0]     w_buf_rdata;
    logic            w_unused;

    assign w_is_csr      = bus_addr_i[c_aw-1];
    assign w_word        = bus_addr_i[c_aw-2:2];
    assign w_busy        = (r_state != c_st_idle);
    assign w_ctrl_sel    = w_is_csr && (w_word == c_iw'(c_csr_ctrl_ofs >> 2));
    assign w_status_sel  = w_is_csr && (w_word == c_iw'(c_csr_status_ofs >> 2));
    assign w_ctrl_we     = bus_we_i && w_ctrl_sel;
    assign w_status_we   = bus_we_i && w_status_sel;
    assign w_buf_we      = bus_we_i && !w_is_csr && !w_busy;
    assign w_len_req     = bus_wdata_i[c_iw:0];
    assign w_len_clamped = (w_len_req > c_len_max) ? c_len_max : w_len_req;
    assign w_tmo_hit     = (TIMEOUT_CYCLES != 0) && (r_tcnt == c_tmo_last);
    assign w_last        = ({1'b0, r_index} == (r_len - 1'b1));
    assign w_index_nxt   = r_index + 1'b1;
    assign w_unused      = ^{bus_addr_i[1:0], bus_wdata_i};

    always_comb begin
        w_status                                  = '0;
        w_status[c_stat_busy_bit]                 = w_busy;
        w_status[c_stat_done_bit]                 = r_done;
        w_status[c_stat_timeout_bit]              = r_timeout;
        w_status[c_stat_wr_err_bit]               = r_wr_err;
        w_status[c_stat_words_lsb +: 8]           = r_words;
    end

    print_buf_regfile #(
        .REG_NUMBER (REG_NUMBER)
    ) u_buf (
        .clk      (clk_sys_i),
        .i_we     (w_buf_we),
        .i_waddr  (w_word),
        .i_wdata  (bus_wdata_i),
        .i_araddr (r_index),
        .o_ardata (w_buf_ardata),
        .i_re     (bus_re_i && !w_is_csr),
        .i_raddr  (w_word),
        .o_rdata  (w_buf_rdata)
    );

    // FSM sets are placed after the W1C clears so a same-cycle set wins
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_state   <= c_st_idle;
            r_en      <= 1'b0;
            r_index   <= '0;
            r_len     <= '0;
            r_addr    <= '0;
            r_tcnt    <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_wr_err  <= 1'b0;
            r_words   <= '0;
        end else begin
            if (w_status_we) begin
                if (bus_wdata_i[c_stat_done_bit])    r_done    <= 1'b0;
                if (bus_wdata_i[c_stat_timeout_bit]) r_timeout <= 1'b0;
                if (bus_wdata_i[c_stat_wr_err_bit])  r_wr_err  <= 1'b0;
            end
            if (bus_we_i && w_busy &&
                (!w_is_csr || (w_ctrl_sel && bus_wdata_i[c_ctrl_start_bit]))) begin
                r_wr_err <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_ctrl_we) begin
                        r_len <= w_len_clamped;
                        if (bus_wdata_i[c_ctrl_start_bit]) begin
                            if (w_len_clamped == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_index <= '0;
                                r_addr  <= '0;
                                r_words <= '0;
                                r_tcnt  <= '0;
                                r_en    <= 1'b1;
                                r_state <= c_st_arm;
                            end
                        end
                    end
                end
                c_st_arm: begin
                    if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_en      <= 1'b0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                        if (!finish_i) r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (finish_i) begin
                        r_words <= r_words + 8'd1;
                        r_en    <= 1'b0;
                        r_state <= c_st_gap;
                    end else if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_en      <= 1'b0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                c_st_gap: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end else begin
                        r_index <= w_index_nxt;
                        r_addr  <= {w_index_nxt, 2'b00};
                        r_tcnt  <= '0;
                        r_en    <= 1'b1;
                        r_state <= c_st_arm;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Read data is captured before this cycle's write takes effect
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_rd_buf    <= 1'b0;
            r_csr_rdata <= '0;
        end else if (bus_re_i) begin
            r_rd_buf    <= !w_is_csr;
            r_csr_rdata <= w_status_sel ? w_status : '0;
        end
    end

    assign bus_rdata_o    = r_rd_buf ? w_buf_rdata : r_csr_rdata;
    assign write_soc_en_o = r_en;
    assign data_addr_o    = r_addr;
    assign data_o         = w_buf_ardata;
    assign irq_o          = r_done | r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_print_ctrl.sv
// ============================================================================
// Module   : tb_print_ctrl
// Brief    : Directed self-checking bench for print_ctrl with a print_sub
//            responder model and an enable-pulse monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_print_ctrl;

    localparam logic [6:0] c_ctrl   = 7'h40;
    localparam logic [6:0] c_status = 7'h44;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [6:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        en;
    logic        finish = 1'b0;
    logic [5:0]  data_addr;
    logic [31:0] data;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    print_ctrl #(
        .REG_NUMBER     (16),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk_sys_i      (clk),
        .rst_i          (rst),
        .bus_we_i       (bus_we),
        .bus_re_i       (bus_re),
        .bus_addr_i     (bus_addr),
        .bus_wdata_i    (bus_wdata),
        .bus_rdata_o    (bus_rdata),
        .write_soc_en_o (en),
        .finish_i       (finish),
        .data_addr_o    (data_addr),
        .data_o         (data),
        .irq_o          (irq)
    );

    // print_sub model: finish drops 2 cycles into a pulse, rises at 5, and
    // stays high after enable falls, so every word after the first sees a
    // stale finish in ARM.
    logic model_on = 1'b1;
    int   mcnt = 0;
    always @(negedge clk) begin
        if (!en) begin
            mcnt = 0;
        end else begin
            mcnt++;
            if (mcnt == 2) finish = 1'b0;
            if (mcnt == 5 && model_on) finish = 1'b1;
        end
    end

    // Record address, data and length of every enable pulse when it ends
    logic [5:0]  pa[$];
    logic [31:0] pd[$];
    int          pl[$];
    logic        en_q = 1'b0;
    int          cur_len = 0;
    always @(negedge clk) begin
        if (en) begin
            cur_len++;
        end else if (en_q) begin
            pa.push_back(data_addr);
            pd.push_back(data);
            pl.push_back(cur_len);
            cur_len = 0;
        end
        en_q = en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_re = 1'b1; bus_addr = a;
        @(negedge clk);
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    task automatic wait_irq(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq) break;
        end
        check(tag, 32'(irq), 32'd1);
    endtask

    task automatic clear_mon();
        pa.delete(); pd.delete(); pl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_en", 32'(en), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_daddr", 32'(data_addr), 32'd0);
        rst = 1'b0;
        bus_read(c_status, rd);
        check("rst_status", rd, 32'd0);

        // Basic 3-word print
        bus_write(7'h00, 32'h41);
        bus_write(7'h04, 32'h42);
        bus_write(7'h08, 32'h43);
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0003);
        wait_irq("basic_irq", 100);
        repeat (2) @(negedge clk);
        check("basic_npulse", 32'(pa.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < pa.size()) begin
                check("basic_addr", 32'(pa[k]), 32'(k * 4));
                check("basic_data", pd[k], 32'h41 + 32'(k));
                check("basic_plen", 32'(pl[k]), 32'd5);
            end
        end
        bus_read(c_status, rd);
        check("basic_status", rd, 32'h0000_0302);
        bus_read(7'h04, rd);
        check("buf_read", rd, 32'h42);
        bus_read(c_ctrl, rd);
        check("ctrl_read", rd, 32'd0);

        // Stale finish from previous run is still high
        bus_write(c_status, 32'h2);
        check("w1c_irq", 32'(irq), 32'd0);
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0002);
        wait_irq("stale_irq", 100);
        repeat (2) @(negedge clk);
        check("stale_npulse", 32'(pa.size()), 32'd2);
        for (int k = 0; k < 2; k++) begin
            if (k < pa.size()) begin
                check("stale_addr", 32'(pa[k]), 32'(k * 4));
                check("stale_plen", 32'(pl[k]), 32'd5);
            end
        end
        bus_read(c_status, rd);
        check("stale_status", rd, 32'h0000_0202);

        // Busy protection
        bus_write(c_status, 32'hE);
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0003);
        bus_write(7'h00, 32'hDEAD_BEEF);
        bus_write(c_ctrl, 32'h8000_0001);
        wait_irq("busy_irq", 100);
        repeat (8) @(negedge clk);
        check("busy_npulse", 32'(pa.size()), 32'd3);
        bus_read(7'h00, rd);
        check("busy_buf0", rd, 32'h41);
        bus_read(c_status, rd);
        check("busy_status", rd, 32'h0000_030A);

        // len = 0: done without any transfer
        bus_write(c_status, 32'hE);
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0000);
        repeat (3) @(negedge clk);
        check("len0_npulse", 32'(pa.size()), 32'd0);
        check("len0_irq", 32'(irq), 32'd1);
        bus_read(c_status, rd);
        check("len0_flags", rd & 32'hF, 32'h2);

        // len = 20 clamps to 16
        bus_write(c_status, 32'hE);
        for (int i = 0; i < 16; i++) bus_write(7'(i * 4), 32'h100 + 32'(i));
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0014);
        wait_irq("len20_irq", 300);
        repeat (2) @(negedge clk);
        check("len20_npulse", 32'(pa.size()), 32'd16);
        if (pa.size() > 0) begin
            check("len20_last_addr", 32'(pa[pa.size()-1]), 32'h3C);
            check("len20_last_data", pd[pd.size()-1], 32'h10F);
        end
        bus_read(c_status, rd);
        check("len20_status", rd, 32'h0000_1002);

        // Timeout: finish never rises
        model_on = 1'b0;
        bus_write(c_status, 32'hE);
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0001);
        wait_irq("tmo_irq", 50);
        repeat (2) @(negedge clk);
        check("tmo_en", 32'(en), 32'd0);
        check("tmo_npulse", 32'(pa.size()), 32'd1);
        if (pl.size() > 0) check("tmo_plen", 32'(pl[0]), 32'd8);
        bus_read(c_status, rd);
        check("tmo_status", rd, 32'h0000_0004);
        bus_write(c_status, 32'h4);
        check("tmo_w1c_irq", 32'(irq), 32'd0);
        model_on = 1'b1;

        // Reset during WAIT of word 1
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0003);
        for (int i = 0; i < 100 && pa.size() == 0; i++) @(negedge clk);
        for (int i = 0; i < 20 && !en; i++) @(negedge clk);
        check("rstw_armed", 32'(en), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_en", 32'(en), 32'd0);
        check("rstw_daddr", 32'(data_addr), 32'd0);
        rst = 1'b0;
        bus_read(c_status, rd);
        check("rstw_status", rd, 32'd0);
        clear_mon();
        bus_write(c_ctrl, 32'h8000_0002);
        wait_irq("rstw_irq", 100);
        repeat (2) @(negedge clk);
        check("rstw_npulse", 32'(pa.size()), 32'd2);
        if (pa.size() > 1) check("rstw_addr1", 32'(pa[1]), 32'h4);
        bus_read(c_status, rd);
        check("rstw_status2", rd, 32'h0000_0202);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
